// File: rtl/mul_hilo_if.sv
// mul_hilo_if: request/result bundle between the EX-stage controller and mul_hilo_unit.
interface mul_hilo_if #(parameter int WIDTH = 32);
  logic start;
  logic [1:0] op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic busy;
  logic done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, srcA, srcB, input busy, done, hi, lo);
  modport slave (input start, op, srcA, srcB, output busy, done, hi, lo);
endinterface

// File: rtl/mul_hilo_unit.sv
// mul_hilo_unit: iterative shift-add MULT/MULTU/MTHI/MTLO with HI/LO registers.
// Defining MUL_EARLY_TERM_EN ends CALC as soon as no multiplier bits remain.
module mul_hilo_unit #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst_n,
  mul_hilo_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH:0] acc_q, acc_d;
  logic neg_q, neg_d;
  logic sgn_a, sgn_b, fin;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] prod_mag, prod;
  assign sgn_a = ~bus.op[0] & bus.srcA[WIDTH-1];
  assign sgn_b = ~bus.op[0] & bus.srcB[WIDTH-1];
  assign mag_a = sgn_a ? -bus.srcA : bus.srcA;
  assign mag_b = sgn_b ? -bus.srcB : bus.srcB;
  // The upper half plus a carry bit collects partial sums; the lower half holds the unconsumed multiplier.
  assign sum = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, mcand_q} : '0);
`ifdef MUL_EARLY_TERM_EN
  logic [WIDTH-1:0] mq_q, mq_d;
  assign fin = (cnt_q == CW'(WIDTH)) || (mq_q == '0);
  assign prod_mag = acc_q[2*WIDTH-1:0] >> (CW'(WIDTH) - cnt_q);
`else
  assign fin = cnt_q == CW'(WIDTH);
  assign prod_mag = acc_q[2*WIDTH-1:0];
`endif
  assign prod = neg_q ? -prod_mag : prod_mag;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    mcand_d = mcand_q;
    acc_d = acc_q;
    neg_d = neg_q;
    hi_d = hi_q;
    lo_d = lo_q;
`ifdef MUL_EARLY_TERM_EN
    mq_d = mq_q;
`endif
    if (state_q == S_IDLE && bus.start) begin
      if (bus.op[1]) begin
        hi_d = bus.op[0] ? hi_q : bus.srcA;
        lo_d = bus.op[0] ? bus.srcA : lo_q;
      end else begin
        state_d = S_CALC;
        cnt_d = '0;
        mcand_d = mag_a;
        acc_d = {{(WIDTH+1){1'b0}}, mag_b};
        neg_d = sgn_a ^ sgn_b;
`ifdef MUL_EARLY_TERM_EN
        mq_d = mag_b;
`endif
      end
    end else if (state_q == S_CALC) begin
      if (fin) begin
        {hi_d, lo_d} = prod;
        state_d = S_DONE;
      end else begin
        acc_d = {sum, acc_q[WIDTH-1:0]} >> 1;
        cnt_d = cnt_q + 1'b1;
`ifdef MUL_EARLY_TERM_EN
        mq_d = mq_q >> 1;
`endif
      end
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      mcand_q <= '0;
      acc_q <= '0;
      neg_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
`ifdef MUL_EARLY_TERM_EN
      mq_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mcand_q <= mcand_d;
      acc_q <= acc_d;
      neg_q <= neg_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
`ifdef MUL_EARLY_TERM_EN
      mq_q <= mq_d;
`endif
    end
  end
  assign bus.busy = state_q != S_IDLE;
  assign bus.done = state_q == S_DONE;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
endmodule

// File: tb/tb_mul_hilo_unit.sv
// tb_mul_hilo_unit: scoreboard bench for mul_hilo_unit; expected products queued at request, compared on done.
module tb_mul_hilo_unit;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb[$];
  logic [63:0] prev;
  mul_hilo_if #(.WIDTH(32)) bus ();
  mul_hilo_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial forever begin
    logic [63:0] e;
    @(posedge clk);
    #1;
    if (bus.done) begin
      if (sb.size() == 0) chk("spurious_done", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("hilo", {bus.hi, bus.lo}, e);
      end
    end
  end
  task automatic run_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    logic signed [63:0] sa, sb64;
    logic [31:0] mag;
    int exp_lat, lat, bcnt, n;
    sa = $signed(a);
    sb64 = $signed(b);
    exp = op[0] ? {32'd0, a} * {32'd0, b} : 64'(sa * sb64);
    mag = (!op[0] && b[31]) ? -b : b;
`ifdef MUL_EARLY_TERM_EN
    exp_lat = 1;
    for (int i = 0; i < 32; i++) if (mag[i]) exp_lat = i + 2;
`else
    exp_lat = 33;
`endif
    sb.push_back(exp);
    bus.start = 1'b1;
    bus.op = op;
    bus.srcA = a;
    bus.srcB = b;
    tick();
    lat = -1;
    bcnt = 0;
    n = 0;
    while (bus.busy && n < 100) begin
      if (n == 0) chk("hold_during_calc", {bus.hi, bus.lo}, prev);
      if (bus.done) lat = n;
      bcnt++;
      bus.start = 1'b1;
      bus.op = 2'($urandom_range(3));
      bus.srcA = $urandom;
      bus.srcB = $urandom;
      tick();
      n++;
    end
    bus.start = 1'b0;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_cycles", 64'(bcnt), 64'(exp_lat + 1));
    tick();
    chk("no_accept_in_done", {63'd0, bus.busy}, 64'd0);
    prev = exp;
  endtask
  initial begin
    int dcnt;
    bus.start = 1'b1;
    bus.op = 2'b00;
    bus.srcA = 32'd5;
    bus.srcB = 32'd6;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_hi", {32'd0, bus.hi}, 64'd0);
    chk("rst_lo", {32'd0, bus.lo}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    rst_n = 1'b1;
    bus.start = 1'b0;
    tick();
    chk("idle_after_rst", {63'd0, bus.busy}, 64'd0);
    prev = 64'd0;
    run_mul(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_max", prev, 64'hFFFFFFFE_00000001);
    run_mul(2'b00, 32'h80000000, 32'h80000000);
    run_mul(2'b00, 32'hFFFFFFFD, 32'h00000007);
    run_mul(2'b00, 32'h00000000, 32'hFFFFFFFF);
    run_mul(2'b00, 32'h80000000, 32'h00000001);
    run_mul(2'b01, 32'd5, 32'd6);
    run_mul(2'b01, 32'h1234, 32'h3);
    run_mul(2'b01, 32'hDEADBEEF, 32'h0);
    for (int i = 0; i < 4; i++) run_mul(2'(i & 1), $urandom, $urandom);
    bus.start = 1'b1;
    bus.op = 2'b10;
    bus.srcA = 32'h12345678;
    tick();
    chk("mthi", {bus.hi, bus.lo}, {32'h12345678, prev[31:0]});
    chk("mthi_flags", {62'd0, bus.busy, bus.done}, 64'd0);
    bus.op = 2'b11;
    bus.srcA = 32'h9ABCDEF0;
    tick();
    bus.start = 1'b0;
    chk("mtlo", {bus.hi, bus.lo}, 64'h12345678_9ABCDEF0);
    chk("mtlo_flags", {62'd0, bus.busy, bus.done}, 64'd0);
    bus.start = 1'b1;
    bus.op = 2'b01;
    bus.srcA = 32'd5;
    bus.srcB = 32'd6;
    tick();
    bus.start = 1'b0;
`ifdef MUL_EARLY_TERM_EN
    tick();
`else
    repeat (9) tick();
`endif
    chk("abort_busy_before", {63'd0, bus.busy}, 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      dcnt += int'(bus.done);
      tick();
    end
    chk("abort_no_done", 64'(dcnt), 64'd0);
    chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mul_hilo_unit.md
Name: mul_hilo_unit

Overview:
- Iterative shift-add multiply unit sitting beside the ALU in the EX stage of the multi-cycle MIPS datapath.
- Consumes the same srcA/srcB operands the ALU receives and executes MULT, MULTU, MTHI and MTLO.
- Holds the architectural HI/LO registers that MFHI/MFLO read through the ALU result mux.
- The controller stalls on busy and resumes on done.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH, split into HI (upper) and LO (lower).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  2  00 MULT (signed), 01 MULTU (unsigned), 10 MTHI, 11 MTLO.
- srcA  input  WIDTH  multiplicand; the source value for MTHI/MTLO.
- srcB  input  WIDTH  multiplier; ignored for MTHI/MTLO.
- busy  output  1  high while a multiply is in flight (CALC and DONE states).
- done  output  1  one-cycle pulse when HI/LO take a new product.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst_n=0 at a posedge):
  - State goes to IDLE.
  - hi=0, lo=0, busy=0, done=0, iteration counter=0.
  - Reset overrides start on the same edge.
  - Reset during CALC aborts the operation; no done pulse follows.
- States and transitions:
  - IDLE, start=1, op=0x: latch the operands and sign info, clear the partial product, go to CALC.
  - IDLE, start=1, op=10: hi<=srcA on that edge, stay in IDLE.
  - IDLE, start=1, op=11: lo<=srcA on that edge, stay in IDLE.
  - MTHI/MTLO never raise busy or done.
  - CALC: one multiplier bit per cycle. If the multiplier LSB is 1, add the multiplicand into the upper half of the 2*WIDTH+1 accumulator, then shift right by one. After WIDTH iterations go to DONE.
  - DONE: {hi,lo}<=final product (negated if the result sign is negative); done=1 for this cycle only; go to IDLE.
- Latency: start accepted at edge T0; busy=1 from T0+1; done=1 and the new hi/lo are visible in the cycle after edge T0+WIDTH+1; busy=0 after edge T0+WIDTH+2.
- A back-to-back start is accepted on the edge at which DONE returns to IDLE is not allowed; the earliest new start is sampled in the first IDLE cycle.
- start while busy is ignored (no queueing).
- hi/lo hold their old values throughout CALC. Reads during busy return the previous result.
- Signed arithmetic (MULT):
  - Operands are converted to magnitudes before iteration.
  - Result sign = srcA[WIDTH-1] XOR srcB[WIDTH-1].
  - A zero product is never negated to a nonzero value.
  - -2^31 * -2^31 = 0x40000000_00000000.
  - -2^31 * 1 = 0xFFFFFFFF_80000000.
- Unsigned arithmetic (MULTU): operands are used as-is; 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE_00000001.
- Overflow is impossible by construction; there is no ovf output.
- Operands are latched at start. srcA/srcB changing during CALC must not affect the result.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- Defined: in CALC, when the remaining unshifted multiplier bits are all zero, the unit shifts the accumulator by the remaining count in one step and goes to DONE on the next edge.
  - Latency becomes (index of highest set multiplier magnitude bit + 2) edges from acceptance.
  - A zero multiplier reaches DONE after 1 CALC cycle.
  - Results are identical to the non-terminating datapath.
- Undefined: fixed WIDTH-cycle CALC regardless of operand values.

Test Plan:
- Reset then idle: rst_n=0 for 2 edges -> hi=0, lo=0, busy=0, done=0; start=1 with rst_n=0 -> state stays IDLE.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 edges done=1, hi=0xFFFFFFFE, lo=0x00000001; busy=1 for exactly 34 cycles (default build).
- MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0. MULT 0xFFFFFFFD(-3) x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0 x 0xFFFFFFFF -> hi=lo=0.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo update on each edge; busy and done never assert.
- Mid-operation: start MULTU 5x6, change srcA/srcB every cycle, then start=1 during CALC -> single done, hi=0, lo=30. Repeat with rst_n=0 at iteration 10 -> no done, hi=lo=0.
- MUL_EARLY_TERM_EN: MULTU 0x1234 x 0x3 -> done within 3 edges of acceptance, lo=0x369C; same stimulus without the macro -> done after 33 edges, same value.
